// File: rtl/df_qp_pkg.sv
// Shared definitions for the deblocking-filter neighbour-QP buffer:
// FSM encoding, QP channel indices and a packed-bus field extractor.
package df_qp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_RESP  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam int unsigned CH_Y  = 0;
    localparam int unsigned CH_CB = 1;
    localparam int unsigned CH_CR = 2;

    // Upper bounds for the generic field extractor; buses up to 32 bits, QPs up to 8 bits.
    localparam int unsigned MAX_QP_W  = 8;
    localparam int unsigned MAX_BUS_W = 32;

    // Extract channel ch (qp_w bits wide, ch0 in LSBs) from a packed QP bus.
    function automatic logic [MAX_QP_W-1:0] qp_field(input logic [MAX_BUS_W-1:0] bus,
                                                     input int unsigned qp_w,
                                                     input int unsigned ch);
        logic [MAX_BUS_W-1:0] mask;
        mask = (MAX_BUS_W'(1) << qp_w) - MAX_BUS_W'(1);
        return MAX_QP_W'((bus >> (ch * qp_w)) & mask);
    endfunction

endpackage

// File: rtl/df_qp_nbr_buf_if.sv
// Request/response interface of the neighbour-QP buffer.
// Average outputs exist only when DF_QP_AVG_EN is defined.
interface df_qp_nbr_buf_if #(
    parameter int unsigned QP_W   = 6,
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned MBX_W  = 7,
    parameter int unsigned MBY_W  = 7
);
    localparam int unsigned BUS_W = NUM_CH * QP_W;

    logic             req_valid;
    logic             req_ready;
    logic [MBX_W-1:0] req_mb_x;
    logic [MBY_W-1:0] req_mb_y;
    logic [BUS_W-1:0] req_qp;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [BUS_W-1:0] rsp_qp_a;
    logic [BUS_W-1:0] rsp_qp_b;
    logic             rsp_avail_a;
    logic             rsp_avail_b;
`ifdef DF_QP_AVG_EN
    logic [BUS_W-1:0] rsp_qp_av_a;
    logic [BUS_W-1:0] rsp_qp_av_b;
`endif
    logic             err_mb_x;

`ifdef DF_QP_AVG_EN
    modport slave (
        input  req_valid, req_mb_x, req_mb_y, req_qp, rsp_ready,
        output req_ready, rsp_valid, rsp_qp_a, rsp_qp_b, rsp_avail_a, rsp_avail_b,
               rsp_qp_av_a, rsp_qp_av_b, err_mb_x
    );
    modport master (
        output req_valid, req_mb_x, req_mb_y, req_qp, rsp_ready,
        input  req_ready, rsp_valid, rsp_qp_a, rsp_qp_b, rsp_avail_a, rsp_avail_b,
               rsp_qp_av_a, rsp_qp_av_b, err_mb_x
    );
`else
    modport slave (
        input  req_valid, req_mb_x, req_mb_y, req_qp, rsp_ready,
        output req_ready, rsp_valid, rsp_qp_a, rsp_qp_b, rsp_avail_a, rsp_avail_b,
               err_mb_x
    );
    modport master (
        output req_valid, req_mb_x, req_mb_y, req_qp, rsp_ready,
        input  req_ready, rsp_valid, rsp_qp_a, rsp_qp_b, rsp_avail_a, rsp_avail_b,
               err_mb_x
    );
`endif

endinterface

// File: rtl/df_qp_line_ram.sv
// 1R1W line buffer of per-column QPs with a registered read port.
// Accesses at addresses >= DEPTH are ignored.
module df_qp_line_ram #(
    parameter int unsigned W      = 18,
    parameter int unsigned DEPTH  = 120,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [W-1:0]      rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W-1:0]      wr_data
);
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_data_q;
    logic [W-1:0] rd_data_d;

    // Read data holds until the next enabled in-range read.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en && (32'(rd_addr) < DEPTH)) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Read register; RAM contents are never cleared so no reset here either.
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/df_qp_nbr_buf.sv
// Neighbour-QP buffer for the deblocking filter: per macroblock returns left (A)
// and top (B) neighbour QPs with availability flags, then commits the current QPs
// to the line buffer and left register.
// Optional feature macro: DF_QP_AVG_EN adds rounded current/neighbour QP averages.
module df_qp_nbr_buf
    import df_qp_pkg::*;
#(
    parameter int unsigned QP_W     = 6,
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned MAX_MB_W = 120,
    parameter int unsigned MBX_W    = 7,
    parameter int unsigned MBY_W    = 7
) (
    input logic           clk,
    input logic           reset,
    df_qp_nbr_buf_if.slave io
);
    localparam int unsigned BUS_W = NUM_CH * QP_W;

    state_t           state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic [MBX_W-1:0] mb_x_q, mb_x_d;
    logic [MBY_W-1:0] mb_y_q, mb_y_d;
    logic [BUS_W-1:0] qp_cur_q, qp_cur_d;
    logic [BUS_W-1:0] left_q, left_d;
    logic             x_ok_q, x_ok_d;
    logic             err_q, err_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [BUS_W-1:0] rsp_qp_a_q, rsp_qp_a_d;
    logic [BUS_W-1:0] rsp_qp_b_q, rsp_qp_b_d;
    logic             avail_a_q, avail_a_d;
    logic             avail_b_q, avail_b_d;

    logic             x_in_range_c;
    logic             ram_rd_en_c;
    logic             ram_wr_en_c;
    logic [BUS_W-1:0] ram_rd_data;

    assign x_in_range_c = (32'(io.req_mb_x) < MAX_MB_W);

    df_qp_line_ram #(
        .W      (BUS_W),
        .DEPTH  (MAX_MB_W),
        .ADDR_W (MBX_W)
    ) u_line_ram (
        .clk     (clk),
        .rd_en   (ram_rd_en_c),
        .rd_addr (io.req_mb_x),
        .rd_data (ram_rd_data),
        .wr_en   (ram_wr_en_c),
        .wr_addr (mb_x_q),
        .wr_data (qp_cur_q)
    );

    // Next-state and datapath: accept, read, respond, commit.
    always_comb begin
        state_d     = state_q;
        mb_x_d      = mb_x_q;
        mb_y_d      = mb_y_q;
        qp_cur_d    = qp_cur_q;
        left_d      = left_q;
        x_ok_d      = x_ok_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_qp_a_d  = rsp_qp_a_q;
        rsp_qp_b_d  = rsp_qp_b_q;
        avail_a_d   = avail_a_q;
        avail_b_d   = avail_b_q;
        ram_rd_en_c = 1'b0;
        ram_wr_en_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (io.req_valid) begin
                    mb_x_d      = io.req_mb_x;
                    mb_y_d      = io.req_mb_y;
                    qp_cur_d    = io.req_qp;
                    x_ok_d      = x_in_range_c;
                    err_d       = err_q | ~x_in_range_c;
                    ram_rd_en_c = x_in_range_c;
                    state_d     = ST_READ;
                end
            end
            ST_READ: begin
                avail_a_d   = (mb_x_q != '0);
                avail_b_d   = (mb_y_q != '0) && x_ok_q;
                rsp_qp_a_d  = (mb_x_q != '0) ? left_q : '0;
                rsp_qp_b_d  = ((mb_y_q != '0) && x_ok_q) ? ram_rd_data : '0;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (io.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                ram_wr_en_c = x_ok_q;
                left_d      = qp_cur_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            mb_x_q      <= '0;
            mb_y_q      <= '0;
            qp_cur_q    <= '0;
            left_q      <= '0;
            x_ok_q      <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_qp_a_q  <= '0;
            rsp_qp_b_q  <= '0;
            avail_a_q   <= 1'b0;
            avail_b_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            mb_x_q      <= mb_x_d;
            mb_y_q      <= mb_y_d;
            qp_cur_q    <= qp_cur_d;
            left_q      <= left_d;
            x_ok_q      <= x_ok_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_qp_a_q  <= rsp_qp_a_d;
            rsp_qp_b_q  <= rsp_qp_b_d;
            avail_a_q   <= avail_a_d;
            avail_b_q   <= avail_b_d;
        end
    end

    assign io.req_ready   = req_ready_q;
    assign io.rsp_valid   = rsp_valid_q;
    assign io.rsp_qp_a    = rsp_qp_a_q;
    assign io.rsp_qp_b    = rsp_qp_b_q;
    assign io.rsp_avail_a = avail_a_q;
    assign io.rsp_avail_b = avail_b_q;
    assign io.err_mb_x    = err_q;

`ifdef DF_QP_AVG_EN
    logic [BUS_W-1:0] av_a_c;
    logic [BUS_W-1:0] av_b_c;

    // Per-channel rounded average of current and neighbour QP; passes qp_cur when unavailable.
    always_comb begin
        logic [QP_W-1:0] cur_f;
        logic [QP_W-1:0] a_f;
        logic [QP_W-1:0] b_f;
        logic [QP_W:0]   sum_a;
        logic [QP_W:0]   sum_b;
        av_a_c = '0;
        av_b_c = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            cur_f = QP_W'(qp_field(MAX_BUS_W'(qp_cur_q), QP_W, ch));
            a_f   = QP_W'(qp_field(MAX_BUS_W'(rsp_qp_a_q), QP_W, ch));
            b_f   = QP_W'(qp_field(MAX_BUS_W'(rsp_qp_b_q), QP_W, ch));
            sum_a = (QP_W+1)'(cur_f) + (QP_W+1)'(a_f) + (QP_W+1)'(1);
            sum_b = (QP_W+1)'(cur_f) + (QP_W+1)'(b_f) + (QP_W+1)'(1);
            av_a_c[ch*QP_W +: QP_W] = avail_a_q ? sum_a[QP_W:1] : cur_f;
            av_b_c[ch*QP_W +: QP_W] = avail_b_q ? sum_b[QP_W:1] : cur_f;
        end
    end

    assign io.rsp_qp_av_a = av_a_c;
    assign io.rsp_qp_av_b = av_b_c;
`endif

endmodule
